// File: rtl/piso_shift_tx.sv
// Parallel-in/serial-out shift-register transmitter.
// A word accepted through a valid/ready handshake is shifted out one bit at a
// time, each bit held for CLK_DIV cycles, followed by a one-cycle done pulse.
// Every output is a register, so ser_out and bit_strb appear on the cycle
// after the edge that decided them.
module piso_shift_tx #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CLK_DIV   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             bit_strb,
    output logic             busy,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH + 1);
    localparam int DCW = $clog2(CLK_DIV + 1);
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] shreg, shreg_nxt;
    logic [BCW-1:0]   bit_cnt, bit_cnt_nxt;
    logic [DCW-1:0]   div_cnt, div_nxt;
    logic             ser_out_nxt, ser_valid_nxt, bit_strb_nxt;
    logic             busy_nxt, done_nxt, load_ready_nxt;

    // Bit that goes on the line first for a given register content.
    function automatic logic first_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Move the next bit to be sent into the head position.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Next-state and next-output decode; outputs default to the idle-low values.
    always_comb begin
        state_nxt      = state;
        shreg_nxt      = shreg;
        bit_cnt_nxt    = bit_cnt;
        div_nxt        = div_cnt;
        ser_out_nxt    = 1'b0;
        ser_valid_nxt  = 1'b0;
        bit_strb_nxt   = 1'b0;
        busy_nxt       = 1'b0;
        done_nxt       = 1'b0;
        load_ready_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (load_valid && load_ready) begin
                    // The first bit is taken straight from data_in so it is
                    // on the line in the very first cycle after acceptance.
                    state_nxt     = SHIFT;
                    shreg_nxt     = data_in;
                    bit_cnt_nxt   = '0;
                    div_nxt       = '0;
                    ser_out_nxt   = first_bit(data_in);
                    ser_valid_nxt = 1'b1;
                    bit_strb_nxt  = 1'b1;
                    busy_nxt      = 1'b1;
                end else begin
                    load_ready_nxt = 1'b1;
                end
            end
            SHIFT: begin
                busy_nxt = 1'b1;
                if (div_cnt == DIV_LAST) begin
                    div_nxt = '0;
                    if (bit_cnt == BIT_LAST) begin
                        state_nxt = DONE;
                        done_nxt  = 1'b1;
                    end else begin
                        shreg_nxt     = shift_word(shreg);
                        bit_cnt_nxt   = bit_cnt + 1'b1;
                        ser_out_nxt   = first_bit(shift_word(shreg));
                        ser_valid_nxt = 1'b1;
                        bit_strb_nxt  = 1'b1;
                    end
                end else begin
                    div_nxt       = div_cnt + 1'b1;
                    ser_out_nxt   = ser_out;
                    ser_valid_nxt = 1'b1;
                end
            end
            DONE: begin
                state_nxt      = IDLE;
                load_ready_nxt = 1'b1;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Shift register, counters and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            ser_out    <= 1'b0;
            ser_valid  <= 1'b0;
            bit_strb   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            load_ready <= 1'b1;
        end else begin
            shreg      <= shreg_nxt;
            bit_cnt    <= bit_cnt_nxt;
            div_cnt    <= div_nxt;
            ser_out    <= ser_out_nxt;
            ser_valid  <= ser_valid_nxt;
            bit_strb   <= bit_strb_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            load_ready <= load_ready_nxt;
        end
    end

endmodule

// File: tb/tb_piso_shift_tx.sv
// Bench for piso_shift_tx: three instances cover MSB-first/div 1,
// LSB-first/div 1 and MSB-first/div 3. Expected serial bits and strobes are
// queued when a word is offered and popped whenever ser_valid is seen.
module tb_piso_shift_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       lv [3];
    logic       lr [3];
    logic       so [3];
    logic       sv [3];
    logic       bs [3];
    logic       bz [3];
    logic       dn [3];

    int sel = 0;
    int n_chk = 0;
    int n_err = 0;
    int done_cnt [3] = '{0, 0, 0};

    typedef struct packed {
        logic ser;
        logic strb;
    } exp_t;
    exp_t exp_q [$];

    logic cur_lr, cur_so, cur_sv, cur_bs, cur_bz, cur_dn;

    always #5 clk = ~clk;

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .CLK_DIV(1)) u_msb_d1 (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv[0]),
        .load_ready(lr[0]), .ser_out(so[0]), .ser_valid(sv[0]),
        .bit_strb(bs[0]), .busy(bz[0]), .done(dn[0]));

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .CLK_DIV(1)) u_lsb_d1 (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv[1]),
        .load_ready(lr[1]), .ser_out(so[1]), .ser_valid(sv[1]),
        .bit_strb(bs[1]), .busy(bz[1]), .done(dn[1]));

    piso_shift_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .CLK_DIV(3)) u_msb_d3 (
        .clk(clk), .reset(reset), .data_in(data_in), .load_valid(lv[2]),
        .load_ready(lr[2]), .ser_out(so[2]), .ser_valid(sv[2]),
        .bit_strb(bs[2]), .busy(bz[2]), .done(dn[2]));

    always_comb begin
        cur_lr = lr[sel];
        cur_so = so[sel];
        cur_sv = sv[sel];
        cur_bs = bs[sel];
        cur_bz = bz[sel];
        cur_dn = dn[sel];
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Scoreboard consumer: every valid serial cycle must match the queue head.
    always @(negedge clk) begin
        if (cur_sv === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("extra_bit", 32'(cur_so), 32'hx);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("ser_out", 32'(cur_so), 32'(e.ser));
                check("bit_strb", 32'(cur_bs), 32'(e.strb));
            end
        end
        for (int i = 0; i < 3; i++) if (dn[i] === 1'b1) done_cnt[i]++;
    end

    task automatic push_frame(input logic [7:0] w, input int div, input bit msb);
        for (int k = 0; k < 8; k++) begin
            for (int d = 0; d < div; d++) begin
                exp_t e;
                e.ser  = msb ? w[7-k] : w[k];
                e.strb = (d == 0);
                exp_q.push_back(e);
            end
        end
    endtask

    // Called just after a negedge with the instance idle: offers a word.
    task automatic offer(input logic [7:0] w, input int div, input bit msb);
        check("ready_before_accept", 32'(cur_lr), 32'd1);
        data_in = w;
        lv[sel] = 1'b1;
        push_frame(w, div, msb);
        @(posedge clk);
    endtask

    // Walks cycles 1..upto after T0 (upto <= n+1 where n+1 is the DONE cycle).
    task automatic observe(input int n, input int upto, input bit hold,
                           input bit chg, input logic [7:0] chg_val);
        for (int c = 1; c <= upto; c++) begin
            @(negedge clk);
            if (!hold && c == 1) lv[sel] = 1'b0;
            if (chg && c == 3) data_in = chg_val;
            if (c <= n) begin
                check("ser_valid", 32'(cur_sv), 32'd1);
                check("busy", 32'(cur_bz), 32'd1);
                check("ready_low", 32'(cur_lr), 32'd0);
                check("done_low", 32'(cur_dn), 32'd0);
            end else begin
                check("done_pulse", 32'(cur_dn), 32'd1);
                check("done_sv", 32'(cur_sv), 32'd0);
                check("done_so", 32'(cur_so), 32'd0);
                check("done_busy", 32'(cur_bz), 32'd1);
                check("done_ready", 32'(cur_lr), 32'd0);
            end
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_ready"}, 32'(cur_lr), 32'd1);
        check({tag, "_busy"}, 32'(cur_bz), 32'd0);
        check({tag, "_done"}, 32'(cur_dn), 32'd0);
        check({tag, "_sv"}, 32'(cur_sv), 32'd0);
    endtask

    initial begin
        reset   = 1'b1;
        data_in = 8'hA5;
        for (int i = 0; i < 3; i++) lv[i] = 1'b0;

        // Reset with load_valid high on every instance.
        for (int i = 0; i < 3; i++) lv[i] = 1'b1;
        for (int r = 0; r < 3; r++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                check("rst_ready", 32'(lr[i]), 32'd1);
                check("rst_so", 32'(so[i]), 32'd0);
                check("rst_sv", 32'(sv[i]), 32'd0);
                check("rst_strb", 32'(bs[i]), 32'd0);
                check("rst_busy", 32'(bz[i]), 32'd0);
                check("rst_done", 32'(dn[i]), 32'd0);
            end
        end
        for (int i = 0; i < 3; i++) lv[i] = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_idle("post_rst");

        // MSB first, CLK_DIV=1, 8'hA5.
        sel = 0;
        offer(8'hA5, 1, 1'b1);
        observe(8, 9, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("a5_c10");

        // LSB first, 8'h01, data_in disturbed mid-frame.
        sel = 1;
        offer(8'h01, 1, 1'b0);
        observe(8, 9, 1'b0, 1'b1, 8'hFF);
        @(negedge clk);
        check_idle("lsb_c10");

        // CLK_DIV=3, 8'hC3.
        sel = 2;
        offer(8'hC3, 3, 1'b1);
        observe(24, 25, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("div3_c26");

        // Back-to-back with load_valid held high throughout.
        sel = 0;
        offer(8'h5A, 1, 1'b1);
        observe(8, 9, 1'b1, 1'b1, 8'h3C);
        @(negedge clk);
        check("b2b_ready_c10", 32'(cur_lr), 32'd1);
        push_frame(8'h3C, 1, 1'b1);
        @(posedge clk);
        observe(8, 9, 1'b0, 1'b0, 8'h00);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check_idle("b2b_tail");
        end

        // Reset mid-frame during cycle 4 of an 8'hFF frame.
        offer(8'hFF, 1, 1'b1);
        observe(8, 4, 1'b0, 1'b0, 8'h00);
        reset = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(negedge clk);
        check("abort_so", 32'(cur_so), 32'd0);
        check_idle("abort");
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_idle("abort_tail");
        end
        offer(8'h96, 1, 1'b1);
        observe(8, 9, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_idle("recover");

        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_cnt_msb_d1", 32'(done_cnt[0]), 32'd4);
        check("done_cnt_lsb_d1", 32'(done_cnt[1]), 32'd1);
        check("done_cnt_msb_d3", 32'(done_cnt[2]), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/piso_shift_tx.md
Name: piso_shift_tx

Overview:
Parameterised parallel-in/serial-out shift-register transmitter, the sending end of the chapter's serial-in/parallel-out receiver.
- Accepts a parallel word through a valid/ready load handshake.
- Shifts the word out one bit at a time, holding each bit for a programmable number of clock cycles.
- Flags frame completion.
- Used wherever a register value must cross a 1-bit link to a SIPO receiver.

Parameters:
WIDTH, 8, word width in bits; legal range is 2 or more.
MSB_FIRST, 1, 1 = data_in[WIDTH-1] is sent first; 0 = data_in[0] is sent first.
CLK_DIV, 1, clock cycles each bit is held on ser_out; legal range is 1 or more.

Ports:
clk  input  1  single clock; all state changes on rising edge.
reset  input  1  synchronous, active-high reset.
data_in  input  WIDTH  parallel word to transmit; sampled only on load acceptance.
load_valid  input  1  producer asserts when data_in is valid.
load_ready  output  1  block can accept a word this cycle.
ser_out  output  1  serial data bit; 0 when idle.
ser_valid  output  1  high on every cycle a frame bit is on ser_out.
bit_strb  output  1  one-cycle pulse on the first cycle of each bit.
busy  output  1  high in SHIFT and DONE states.
done  output  1  one-cycle pulse after the last bit.

Behaviour:
- All outputs are registered. All counter widths are $clog2-based and sized to hold WIDTH and CLK_DIV.
- Reset is synchronous. While reset is high at an edge, all of the following take effect after that edge:
  - state = IDLE
  - load_ready = 1
  - ser_out = ser_valid = bit_strb = busy = done = 0
  - shift register, bit counter and divider counter = 0
- Reset mid-frame aborts the frame with no done pulse. Reset has priority over every other event.
- FSM states are IDLE, SHIFT and DONE.
- IDLE:
  - load_ready = 1.
  - Acceptance happens at an edge where load_valid = 1 and load_ready = 1. That edge is T0.
  - At T0: data_in is captured into the shift register, the bit counter and divider are cleared, and the state moves to SHIFT.
- SHIFT:
  - Cycles 1..WIDTH*CLK_DIV after T0.
  - ser_valid = 1, busy = 1, load_ready = 0.
  - Bit k (k = 0..WIDTH-1) is presented during cycles k*CLK_DIV+1 .. (k+1)*CLK_DIV.
  - bit_strb = 1 only on cycle k*CLK_DIV+1.
  - Bit order follows MSB_FIRST. The register shifts by one when the divider reaches CLK_DIV-1.
  - After the last bit's final cycle, the state moves to DONE.
- DONE:
  - Exactly one cycle, at cycle WIDTH*CLK_DIV+1.
  - done = 1, busy = 1, ser_valid = 0, ser_out = 0, load_ready = 0.
  - Next state is IDLE.
- Back-to-back frames: the earliest next acceptance is the edge ending cycle WIDTH*CLK_DIV+2. The minimum frame period is therefore WIDTH*CLK_DIV+2 cycles.
- load_valid while load_ready = 0 is ignored. The word is not queued, and the producer must hold it.
- Changes on data_in after T0 have no effect on the frame in flight.
- With CLK_DIV = 1, bit_strb equals ser_valid.

Test Plan:
1. Reset check: assert reset for 3 cycles with load_valid = 1 → load_ready = 1 and every other output 0. No acceptance occurs while reset is high.
2. WIDTH=8, MSB_FIRST=1, CLK_DIV=1, data_in = 8'hA5 accepted at T0:
   - cycles 1–8: ser_out = 1,0,1,0,0,1,0,1 with ser_valid = 1;
   - cycle 9: done = 1;
   - cycle 10: load_ready = 1.
3. MSB_FIRST=0, CLK_DIV=1, data_in = 8'h01 → ser_out = 1 at cycle 1, then 0 for cycles 2–8. Change data_in to 8'hFF at cycle 3 → the serial stream is unchanged.
4. CLK_DIV=3, data_in = 8'hC3:
   - each bit is held 3 cycles;
   - bit_strb pulses at cycles 1,4,7,…,22;
   - ser_valid is high for cycles 1–24;
   - done = 1 at cycle 25.
5. load_valid held high continuously with 8'h5A then 8'h3C, CLK_DIV=1:
   - second acceptance at the edge ending cycle 10;
   - second frame occupies cycles 11–18;
   - load_valid pulses during busy produce no extra frames.
6. Reset asserted at cycle 4 of an 8'hFF frame → after that edge: ser_out = 0, ser_valid = 0, busy = 0, load_ready = 1, and no done pulse. A new word is accepted normally once reset is released.
